divide_24: RTL and testbench
============================

# divide_24

Sequential unsigned 24-bit mantissa divider for the FPU datapath, the inverse counterpart of the 24-bit mantissa multiplier. It computes {A, 24'b0} / B by restoring radix-2 division, one quotient bit per clock. It feeds the float-divide normalise/round stage with a 48-bit quotient, the remainder and a sticky bit. It uses the same input_ready/output_ready handshake style as the multiplier.

## Interface
- No parameters; all widths are fixed by the 24-bit mantissa format.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `A`  in  24  dividend mantissa, unsigned.
- `B`  in  24  divisor mantissa, unsigned.
- `div_24_input_ready`  in  1  request to start; sampled only when the block is accepting.
- `quotient`  out  48  floor({A,24'b0} / B).
- `remainder`  out  24  {A,24'b0} mod B.
- `sticky`  out  1  |remainder.
- `div_by_zero`  out  1  last accepted operation had B == 0.
- `busy`  out  1  a division is in progress.
- `div_24_output_ready`  out  1  one-cycle pulse: results valid.

## Operation
- States: IDLE, BUSY, DONE.
- Accepting means IDLE or DONE. On an edge with accepting and div_24_input_ready = 1:
  - latch A and B;
  - clear the partial remainder (25 bit) and quotient shift register;
  - set iteration counter to 0;
  - if B != 0, go to BUSY.
  - if B == 0, go directly to DONE with quotient = 48'hFFFF_FFFF_FFFF, remainder = 0, sticky = 0, div_by_zero = 1.
- BUSY iteration i (0..47), one per edge:
  - r' = {r[23:0], d_i}, where d_i is bit (47-i) of {A,24'b0}, i.e. A[23..0] then 24 zeros.
  - if r' >= {1'b0,B}: r = r' - B and q bit = 1; else r = r' and q bit = 0.
  - q shifts left, new bit into the LSB.
  - After iteration 47: go to DONE; drive quotient = q, remainder = r[23:0], sticky = |r, div_by_zero = 0.
- DONE lasts exactly one cycle and then returns to IDLE, unless a new request is accepted in that cycle (back-to-back operation).
- div_24_input_ready is ignored while BUSY. A and B may change freely after the accept edge.
- quotient, remainder, sticky and div_by_zero hold their values until the next DONE; they are not cleared on a new accept.
- busy = (state == BUSY). div_24_output_ready = (state == DONE).
- Normalised operands (A[23] = B[23] = 1) give a quotient in [2^23, 2^25); bit 24 indicates the result is ≥ 1.0. Normalisation is the consumer's job.

## Timing
- Reset, asynchronous and effective mid-operation:
  - state = IDLE, counter = 0;
  - quotient = 0, remainder = 0, sticky = 0, div_by_zero = 0, busy = 0, div_24_output_ready = 0;
  - any in-flight division is discarded and produces no output_ready pulse.
- After rst_n deasserts, the first rising edge may accept a request.
- Normal latency, with the accept at edge k:
  - busy is high during cycles k+1 .. k+48;
  - results update at edge k+48;
  - div_24_output_ready is high for exactly the cycle after edge k+48.
- Divide-by-zero latency: results update at accept edge k; output_ready is high for the cycle after edge k; busy is never asserted.
- Throughput: a new accept can happen on the edge that ends DONE, giving 49 cycles per division with a continuous request.
- Request held high throughout: exactly one accept per DONE/IDLE opportunity, no double accept.

## Test plan
- A=0x800000, B=0x800000, start pulse -> output_ready exactly 48 cycles after accept; quotient=0x000001000000, remainder=0, sticky=0, div_by_zero=0.
- A=0x800000, B=0xC00000 -> quotient=0x000000AAAAAA, remainder=0x800000, sticky=1; busy high for 48 cycles.
- A=0xC00000, B=0x800000, then a new request (A=0xFFFFFF, B=0x000001) on the DONE cycle -> first quotient=0x000001800000; second accepted without an IDLE gap, quotient=0xFFFFFF000000, remainder=0.
- B=0, A=0x123456 -> next cycle output_ready=1, div_by_zero=1, quotient all ones, busy never 1; a following normal op clears div_by_zero.
- Start A=0xFFFFFF, B=0x800001; assert rst_n=0 at iteration 20 -> all outputs 0 immediately, no output_ready pulse; a fresh op after release gives the correct result.
- Toggle A, B and div_24_input_ready randomly during BUSY -> no effect on the result or timing; compare against a reference model over 1000 random non-zero B values.

Source files
------------

// File: rtl/divide_24.sv
// -----------------------------------------------------------------------------
// divide_24
//   Sequential unsigned mantissa divider. Computes {A, 24'b0} / B by restoring
//   radix-2 division, one quotient bit per clock (48 iterations). Feeds the
//   float-divide normalise/round stage with the quotient, remainder and sticky.
//
// Ports
//   clk                  in   1   system clock, rising edge
//   rst_n                in   1   asynchronous active-low reset
//   A                    in  24   dividend mantissa (unsigned)
//   B                    in  24   divisor mantissa (unsigned)
//   div_24_input_ready   in   1   start request, sampled in IDLE or DONE
//   quotient             out 48   floor({A,24'b0} / B), all ones when B == 0
//   remainder            out 24   {A,24'b0} mod B, zero when B == 0
//   sticky               out  1   |remainder
//   div_by_zero          out  1   last accepted operation had B == 0
//   busy                 out  1   division in progress
//   div_24_output_ready  out  1   one-cycle pulse, results valid
// -----------------------------------------------------------------------------
module divide_24 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] A,
  input  logic [23:0] B,
  input  logic        div_24_input_ready,
  output logic [47:0] quotient,
  output logic [23:0] remainder,
  output logic        sticky,
  output logic        div_by_zero,
  output logic        busy,
  output logic        div_24_output_ready
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state, state_next;

  // Dividend bits are consumed MSB first; zeros shift in behind A so that
  // iterations 24..47 bring down the 24 appended zero bits.
  logic [23:0] a_sh;
  logic [23:0] b_reg;
  // The partial remainder is always < B after an iteration, so 24 bits hold
  // it; the 25th bit only exists transiently in r_shift/r_next.
  logic [23:0] r;
  logic [47:0] q;
  logic [5:0]  cnt;

  logic        accept;
  logic        last_iter;
  logic [24:0] r_shift;
  logic        q_bit;
  logic [24:0] r_next;
  logic [47:0] q_next;

  assign accept    = (state != BUSY) && div_24_input_ready;
  assign last_iter = (cnt == 6'd47);

  // One restoring-division step.
  always_comb begin
    r_shift = {r, a_sh[23]};
    q_bit   = (r_shift >= {1'b0, b_reg});
    r_next  = q_bit ? (r_shift - {1'b0, b_reg}) : r_shift;
    q_next  = {q[46:0], q_bit};
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaults are assigned before the case so no path leaves state_next,
  // busy or div_24_output_ready unassigned, which would infer a latch.
  always_comb begin
    state_next          = state;
    busy                = (state == BUSY);
    div_24_output_ready = (state == DONE);
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          // A zero divisor skips the iteration loop entirely.
          state_next = (B == 24'd0) ? DONE : BUSY;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath register, including the working state, is reset so
  // a mid-operation reset leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_reg       <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_reg <= B;
      r     <= '0;
      q     <= '0;
      cnt   <= '0;
      if (B == 24'd0) begin
        quotient    <= '1;
        remainder   <= '0;
        sticky      <= 1'b0;
        div_by_zero <= 1'b1;
      end
    end else if (state == BUSY) begin
      a_sh <= {a_sh[22:0], 1'b0};
      r    <= r_next[23:0];
      q    <= q_next;
      cnt  <= cnt + 6'd1;
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next[23:0];
        sticky      <= |r_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divide_24.sv
// -----------------------------------------------------------------------------
// tb_divide_24
//   Self-checking bench for divide_24: directed vector table, back-to-back and
//   held-request sequences, mid-operation reset, and randomized operations
//   compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_divide_24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] A = '0;
  logic [23:0] B = '0;
  logic        div_24_input_ready = 1'b0;
  logic [47:0] quotient;
  logic [23:0] remainder;
  logic        sticky;
  logic        div_by_zero;
  logic        busy;
  logic        div_24_output_ready;

  divide_24 dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .A                   (A),
    .B                   (B),
    .div_24_input_ready  (div_24_input_ready),
    .quotient            (quotient),
    .remainder           (remainder),
    .sticky              (sticky),
    .div_by_zero         (div_by_zero),
    .busy                (busy),
    .div_24_output_ready (div_24_output_ready)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [47:0] prev_q   = '0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] q;
    logic [23:0] r;
    bit          chain;  // issue the next vector in this one's DONE cycle
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain 48-bit integer division of the widened dividend.
  task automatic model(input logic [23:0] a, input logic [23:0] b,
                       output logic [47:0] q, output logic [23:0] r);
    logic [47:0] dd;
    logic [47:0] rem;
    dd = {a, 24'b0};
    if (b == 24'd0) begin
      q = '1;
      r = '0;
    end else begin
      q   = dd / {24'b0, b};
      rem = dd % {24'b0, b};
      r   = rem[23:0];
    end
  endtask

  // Drive a request, let it be accepted at the next edge, then scramble inputs.
  task automatic issue(input logic [23:0] a, input logic [23:0] b);
    A = a;
    B = b;
    div_24_input_ready = 1'b1;
    @(posedge clk);
    #1;
    div_24_input_ready = 1'b0;
    A = 24'($urandom);
    B = 24'($urandom);
  endtask

  // Called in the cycle after the accept edge. Returns in the DONE cycle.
  task automatic wait_done(input string name, input logic [23:0] b,
                           input logic [47:0] eq, input logic [23:0] er,
                           input bit toggle);
    int c;
    int busy_cnt;
    c        = 1;
    busy_cnt = 0;
    while (!div_24_output_ready && c < 80) begin
      if (busy) busy_cnt++;
      if (c == 1) check({name, " hold"}, 64'(quotient), 64'(prev_q));
      if (toggle) begin
        div_24_input_ready = 1'($urandom_range(0, 1));
        A = 24'($urandom);
        B = 24'($urandom);
      end
      @(posedge clk);
      #1;
      c++;
    end
    div_24_input_ready = 1'b0;
    check({name, " latency"},  64'(c),        (b == 24'd0) ? 64'd1 : 64'd49);
    check({name, " busy_cyc"}, 64'(busy_cnt), (b == 24'd0) ? 64'd0 : 64'd48);
    check({name, " ordy"},     64'(div_24_output_ready), 64'd1);
    check({name, " busy_dn"},  64'(busy),     64'd0);
    check({name, " quot"},     64'(quotient), 64'(eq));
    check({name, " rem"},      64'(remainder), 64'(er));
    check({name, " sticky"},   64'(sticky),   64'(er != 24'd0));
    check({name, " dbz"},      64'(div_by_zero), 64'(b == 24'd0));
    prev_q = eq;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [47:0] mq;
    logic [23:0] mr;
    logic [23:0] ra;
    logic [23:0] rb;
    int          c;

    vecs[0] = '{24'h800000, 24'h800000, 48'h000001000000, 24'h000000, 1'b0};
    vecs[1] = '{24'h800000, 24'hC00000, 48'h000000AAAAAA, 24'h800000, 1'b0};
    vecs[2] = '{24'hC00000, 24'h800000, 48'h000001800000, 24'h000000, 1'b1};
    vecs[3] = '{24'hFFFFFF, 24'h000001, 48'hFFFFFF000000, 24'h000000, 1'b0};
    vecs[4] = '{24'h123456, 24'h000000, 48'hFFFFFFFFFFFF, 24'h000000, 1'b0};
    vecs[5] = '{24'h000001, 24'hFFFFFF, 48'h000000000001, 24'h000001, 1'b0};

    // Reset state.
    #1;
    check("rst quot",  64'(quotient),  64'd0);
    check("rst rem",   64'(remainder), 64'd0);
    check("rst sticky", 64'(sticky),   64'd0);
    check("rst dbz",   64'(div_by_zero), 64'd0);
    check("rst busy",  64'(busy),      64'd0);
    check("rst ordy",  64'(div_24_output_ready), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].b, vecs[i].q, vecs[i].r, 1'b0);
      if (!vecs[i].chain) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d pulse", i), 64'(div_24_output_ready), 64'd0);
      end
    end

    // Request held high: one accept per DONE opportunity, 49 cycles apart.
    A = 24'h800000;
    B = 24'h800000;
    div_24_input_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      c = 1;
      while (!div_24_output_ready && c < 80) begin
        @(posedge clk);
        #1;
        c++;
      end
      check($sformatf("held lat%0d", k), 64'(c), 64'd49);
      check($sformatf("held quot%0d", k), 64'(quotient), 64'h000001000000);
      if (k == 0) begin
        @(posedge clk);
        #1;
        check("held rebusy", 64'(busy), 64'd1);
      end
    end
    div_24_input_ready = 1'b0;
    @(posedge clk);
    #1;
    check("held idle busy", 64'(busy), 64'd0);
    check("held idle ordy", 64'(div_24_output_ready), 64'd0);
    prev_q = 48'h000001000000;

    // Reset at iteration 20, then a fresh operation.
    issue(24'hFFFFFF, 24'h800001);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst quot",  64'(quotient),  64'd0);
    check("midrst rem",   64'(remainder), 64'd0);
    check("midrst sticky", 64'(sticky),   64'd0);
    check("midrst dbz",   64'(div_by_zero), 64'd0);
    check("midrst busy",  64'(busy),      64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("midrst ordy", 64'(div_24_output_ready), 64'd0);
    end
    rst_n  = 1'b1;
    prev_q = '0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (div_24_output_ready) check("midrst late pulse", 64'd1, 64'd0);
    end
    model(24'hFFFFFF, 24'h800001, mq, mr);
    issue(24'hFFFFFF, 24'h800001);
    wait_done("post_rst", 24'h800001, mq, mr, 1'b0);

    // Randomized operations with input noise while busy.
    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom_range(1, 32'hFFFFFF));
      if (i % 4 == 0) begin
        ra[23] = 1'b1;
        rb[23] = 1'b1;
      end
      model(ra, rb, mq, mr);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      issue(ra, rb);
      wait_done($sformatf("rnd%0d a=%h b=%h", i, ra, rb), rb, mq, mr, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
